sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters: RTL and testbench

//  Consumes the per-frame RX status stream from the RX status error adapter and accumulates

---
 rtl/sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters.sv | 143 ++++++++++++++
 tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters.sv
// RX statistics block: a two-stage pipeline feeding eleven saturating frame/octet/error counters,
// read and cleared through an Avalon-MM CSR slave with a shared hi-word snapshot.
module sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters #(
  parameter int CNT_W = 36
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [39:0] in_data,
  input  logic [6:0]  in_error,
  input  logic [4:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        csr_readdatavalid
);

  localparam int N_CNT = 11;
  localparam int HI_W  = CNT_W - 32;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  logic                        s1_valid_r;
  logic [18:0]                 s1_data_r;
  logic [4:0]                  s1_error_r;   // {phy, crc, len, oversize, undersize}
  logic [N_CNT-1:0][CNT_W-1:0] cnt_r;
  logic [N_CNT-1:0][CNT_W-1:0] inc_s;
  logic [HI_W-1:0]             snap_r;
  logic [31:0]                 hi_ext_s;
  logic [31:0]                 rd_mux_s;
  logic [3:0]                  idx_s;
  logic                        snap_load_s;
  logic                        err_any_s;
  logic                        clear_s;
  logic                        unused_s;

  assign unused_s = ^{in_data[39:19], in_error[5:4], csr_writedata[31:1]};
  assign clear_s  = csr_write & (csr_address == 5'd31) & csr_writedata[0];
  assign idx_s    = csr_address[4:1];

  // Stage 1: capture the status beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 19'd0;
      s1_error_r <= 5'd0;
    end else begin
      s1_valid_r <= in_valid;
      s1_data_r  <= in_data[18:0];
      s1_error_r <= {in_error[6], in_error[3:0]};
    end
  end

  // Per-counter increment for the beat in stage 1
  always_comb begin
    inc_s        = '0;
    err_any_s    = |s1_error_r;
    inc_s[0][0]  = ~err_any_s;
    inc_s[1][0]  = err_any_s;
    inc_s[2][0]  = s1_error_r[3];
    inc_s[3][0]  = s1_error_r[0];
    inc_s[4][0]  = s1_error_r[1];
    inc_s[5][0]  = s1_error_r[2];
    inc_s[6][0]  = s1_error_r[4];
    if (!err_any_s) begin
      inc_s[7][15:0] = s1_data_r[15:0];
    end else begin
      inc_s[7] = '0;
    end
    inc_s[8][0]  = ~err_any_s & s1_data_r[16];
    inc_s[9][0]  = ~err_any_s & s1_data_r[17];
    inc_s[10][0] = s1_data_r[18];
  end

  // Stage 2: counters; a CSR clear drops the beat currently in stage 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear_s) begin
      cnt_r <= '0;
    end else if (s1_valid_r) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_r[i] <= sat_add(cnt_r[i], inc_s[i]);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // CSR read decode; a lo-word read also requests a hi snapshot
  always_comb begin
    hi_ext_s             = '0;
    hi_ext_s[HI_W-1:0]   = snap_r;
    rd_mux_s             = 32'd0;
    snap_load_s          = 1'b0;
    if (csr_address == 5'd31) begin
      rd_mux_s = 32'h0000_0001;
    end else if (csr_address < 5'd22) begin
      if (csr_address[0]) begin
        rd_mux_s = hi_ext_s;
      end else begin
        rd_mux_s    = cnt_r[idx_s][31:0];
        snap_load_s = 1'b1;
      end
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // CSR response and hi snapshot; a same-cycle clear lands after the read is served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata      <= 32'd0;
      csr_readdatavalid <= 1'b0;
      snap_r            <= '0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) begin
        csr_readdata <= rd_mux_s;
      end else begin
        csr_readdata <= csr_readdata;
      end
      if (clear_s) begin
        snap_r <= '0;
      end else if (csr_read && snap_load_s) begin
        snap_r <= cnt_r[idx_s][CNT_W-1:32];
      end else begin
        snap_r <= snap_r;
      end
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters.sv
// Self-checking bench for the RX stat counters: a counter model predicts CSR read data,
// expected words are queued at read issue and popped when csr_readdatavalid arrives.
module tb_sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters;

  localparam int CNT_W = 36;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [39:0] in_data = 40'd0;
  logic [6:0]  in_error = 7'd0;
  logic [4:0]  csr_address = 5'd0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = 32'd0;
  logic [31:0] csr_readdata;
  logic        csr_readdatavalid;

  always #5 clk = ~clk;

  sonic_v1_15_pcs_eth_10g_mac_rx_stat_counters #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_error),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid)
  );

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0]         m [11];
  logic [CNT_W-33:0]        m_snap;
  logic [31:0]              exp_q [$];
  logic [10:0][CNT_W-1:0]   force_val;

  function automatic logic [CNT_W-1:0] sadd(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 11; i++) m[i] = '0;
    m_snap = '0;
  endtask

  task automatic model_beat(input logic [15:0] len, input logic [6:0] err,
                            input logic mc, input logic bc, input logic pz);
    logic ea;
    ea = err[0] | err[1] | err[2] | err[3] | err[6];
    if (!ea) m[0] = sadd(m[0], CNT_W'(1));
    if (ea)  m[1] = sadd(m[1], CNT_W'(1));
    if (err[3]) m[2] = sadd(m[2], CNT_W'(1));
    if (err[0]) m[3] = sadd(m[3], CNT_W'(1));
    if (err[1]) m[4] = sadd(m[4], CNT_W'(1));
    if (err[2]) m[5] = sadd(m[5], CNT_W'(1));
    if (err[6]) m[6] = sadd(m[6], CNT_W'(1));
    if (!ea) m[7] = sadd(m[7], CNT_W'(len));
    if (!ea && mc) m[8] = sadd(m[8], CNT_W'(1));
    if (!ea && bc) m[9] = sadd(m[9], CNT_W'(1));
    if (pz) m[10] = sadd(m[10], CNT_W'(1));
  endtask

  task automatic drive_beat(input logic [15:0] len, input logic [6:0] err,
                            input logic mc, input logic bc, input logic pz);
    in_valid = 1'b1;
    in_data  = {21'h1F_FFFF, pz, bc, mc, len};
    in_error = err;
    model_beat(len, err, mc, bc, pz);
  endtask

  // One beat followed by an idle cycle so the next read lands at N+2
  task automatic beat(input logic [15:0] len, input logic [6:0] err,
                      input logic mc, input logic bc, input logic pz);
    drive_beat(len, err, mc, bc, pz);
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic do_read(input logic [4:0] addr, input string name);
    logic [31:0] e;
    logic [31:0] got_data;
    bit got;
    if (addr == 5'd31) e = 32'h1;
    else if (addr >= 5'd22) e = 32'h0;
    else if (!addr[0]) begin
      e = m[addr >> 1][31:0];
      m_snap = m[addr >> 1][CNT_W-1:32];
    end else e = 32'(m_snap);
    exp_q.push_back(e);
    csr_address = addr;
    csr_read = 1'b1;
    cyc();
    csr_read = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      if (csr_readdatavalid) got = 1'b1;
      else cyc();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no readdatavalid, required data 0x%08h", name, exp_q.pop_front());
    end else begin
      got_data = csr_readdata;
      e = exp_q.pop_front();
      if (got_data !== e) begin
        errors++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", name, got_data, e);
      end
    end
    cyc();
  endtask

  task automatic csr_wr(input logic [4:0] addr, input logic [31:0] data);
    csr_address = addr;
    csr_writedata = data;
    csr_write = 1'b1;
    cyc();
    csr_write = 1'b0;
    if (addr == 5'd31 && data[0]) model_clear();
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) cyc();
    checks++;
    if (csr_readdatavalid !== 1'b0 || csr_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdv=%b data=0x%08h, required 0/0", csr_readdatavalid, csr_readdata);
    end
    reset_n = 1'b1;
    cyc();
    do_read(5'd0,  "reset_frames_ok");
    do_read(5'd14, "reset_octets_lo");
    do_read(5'd31, "block_present");
    do_read(5'd25, "reserved_addr");
  endtask

  task automatic test_good_frame();
    csr_wr(5'd31, 32'h1);
    beat(16'd64, 7'd0, 1'b1, 1'b0, 1'b0);
    do_read(5'd0,  "good_frames_ok");
    do_read(5'd2,  "good_frames_err");
    do_read(5'd14, "good_octets");
    do_read(5'd16, "good_mcast");
    do_read(5'd18, "good_bcast");
    do_read(5'd20, "good_pause");
  endtask

  task automatic test_error_frame();
    csr_wr(5'd31, 32'h1);
    beat(16'd100, 7'b100_1001, 1'b1, 1'b1, 1'b1);
    do_read(5'd0,  "err_frames_ok");
    do_read(5'd2,  "err_frames_err");
    do_read(5'd4,  "err_crc");
    do_read(5'd6,  "err_undersize");
    do_read(5'd8,  "err_oversize");
    do_read(5'd10, "err_len");
    do_read(5'd12, "err_phy");
    do_read(5'd14, "err_octets");
    do_read(5'd16, "err_mcast");
    do_read(5'd20, "err_pause");
    beat(16'd60, 7'b011_0110, 1'b0, 1'b0, 1'b0);
    do_read(5'd2,  "ignored_bits_frames_err");
    do_read(5'd8,  "ignored_bits_oversize");
  endtask

  task automatic test_back_to_back();
    csr_wr(5'd31, 32'h1);
    for (int i = 0; i < 1000; i++) begin
      drive_beat(16'd1518, 7'd0, 1'b0, i[0], 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    do_read(5'd0,  "b2b_frames_ok");
    do_read(5'd1,  "b2b_frames_ok_hi");
    do_read(5'd14, "b2b_octets_lo");
    do_read(5'd15, "b2b_octets_hi");
    do_read(5'd18, "b2b_bcast");
  endtask

  task automatic test_saturation();
    csr_wr(5'd31, 32'h1);
    force_val = dut.cnt_r;
    force_val[7] = {CNT_W{1'b1}} - CNT_W'(99);
    force dut.cnt_r = force_val;
    #1;
    release dut.cnt_r;
    m[7] = force_val[7];
    cyc();
    beat(16'd1518, 7'd0, 1'b0, 1'b0, 1'b0);
    do_read(5'd14, "sat_octets_lo");
    do_read(5'd15, "sat_octets_hi");
    beat(16'd1518, 7'd0, 1'b0, 1'b0, 1'b0);
    do_read(5'd14, "sat_stick_lo");
    do_read(5'd15, "sat_stick_hi");
    do_read(5'd0,  "sat_frames_ok");
  endtask

  task automatic test_snapshot();
    csr_wr(5'd31, 32'h1);
    force_val = dut.cnt_r;
    force_val[7] = 36'h1_0000_0005;
    force dut.cnt_r = force_val;
    #1;
    release dut.cnt_r;
    m[7] = force_val[7];
    cyc();
    do_read(5'd14, "snap_lo");
    beat(16'hFFFB, 7'd0, 1'b0, 1'b0, 1'b0);
    do_read(5'd15, "snap_hi_stale");
    do_read(5'd14, "snap_lo_new");
    do_read(5'd15, "snap_hi_new");
  endtask

  task automatic test_clear();
    csr_wr(5'd31, 32'h1);
    beat(16'd10, 7'd0, 1'b0, 1'b0, 1'b0);
    // beat A reaches stage 2 in the clear cycle, beat B sits in stage 1
    drive_beat(16'd100, 7'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive_beat(16'd200, 7'd0, 1'b0, 1'b0, 1'b0);
    csr_address = 5'd31;
    csr_writedata = 32'h1;
    csr_write = 1'b1;
    cyc();
    in_valid = 1'b0;
    csr_write = 1'b0;
    model_clear();
    model_beat(16'd200, 7'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    do_read(5'd0,  "clear_frames_ok");
    do_read(5'd14, "clear_octets");
    csr_wr(5'd31, 32'h0);
    csr_wr(5'd0,  32'h1);
    do_read(5'd0,  "ignored_write_frames_ok");
    do_read(5'd14, "ignored_write_octets");
    // read and clear in the same cycle
    exp_q.push_back(32'h1);
    csr_address = 5'd31;
    csr_writedata = 32'h1;
    csr_read = 1'b1;
    csr_write = 1'b1;
    cyc();
    csr_read = 1'b0;
    csr_write = 1'b0;
    model_clear();
    checks++;
    if (csr_readdatavalid !== 1'b1 || csr_readdata !== exp_q[0]) begin
      errors++;
      $display("FAIL rd_wr_same_cycle: got rdv=%b data=0x%08h, required 1/0x%08h",
               csr_readdatavalid, csr_readdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
    cyc();
    do_read(5'd0, "post_rdwr_frames_ok");
    beat(16'd64, 7'd0, 1'b0, 1'b0, 1'b0);
    do_read(5'd0, "after_clear_next_beat");
  endtask

  task automatic test_reset_mid_read();
    beat(16'd64, 7'd0, 1'b0, 1'b0, 1'b0);
    csr_address = 5'd0;
    csr_read = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (csr_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got rdv=%b, required 0", csr_readdatavalid);
    end
    cyc();
    csr_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (csr_readdatavalid !== 1'b0 || csr_readdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold: got rdv=%b data=0x%08h, required 0/0", csr_readdatavalid, csr_readdata);
      end
    end
    reset_n = 1'b1;
    model_clear();
    cyc();
    do_read(5'd0,  "post_reset_frames_ok");
    do_read(5'd14, "post_reset_octets");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_error_frame();
    test_back_to_back();
    test_saturation();
    test_snapshot();
    test_clear();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
